move_scheduler: RTL and testbench
=================================

# move_scheduler

Sequencer for the shared move-prediction datapath of the tetris field. Latches player move requests and gravity ticks, arbitrates them onto one predictor evaluation per move, and commits the registered piece state (block, X, Y) only when the predictor reports legal. It also drives the lock → line-clear → spawn sequence and flags game-over. It sits between the keyboard/gravity logic and the combinational left/right/rotate/down predictors, which it selects through `moveSel`.

## Interface
- `SPAWN_X`, 8: column loaded into `curX` on spawn.
- `SPAWN_Y`, 0: row loaded into `curY` on spawn.
- `clk` in 1: system clock.
- `resetn` in 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `reqLeft`, `reqRight`, `reqRotate`, `reqDown` in 1 each: single-cycle player request pulses.
- `tick` in 1: single-cycle gravity pulse; same meaning as `reqDown`.
- `moveSel` out 3: predictor select. 0 = left, 1 = right, 2 = rotate, 3 = down, 4 = check (in place).
- `curBlock` out 16, `curX` out 5, `curY` out 5: registered piece state fed to the predictors.
- `predOK` in 1: selected predictor reports the move is legal.
- `predTouch` in 1: selected predictor reports bottom contact.
- `predRotBlock` in 16: anticlockwise-rotated `curBlock`.
- `fieldWe` out 1: one-cycle pulse; the external field register captures the piece merged into the field.
- `clearReq` out 1: level signal; asks the line-clear unit to run.
- `clearDone` in 1: pulse from the line-clear unit.
- `spawnReq` out 1: level signal; asks the piece generator for a new piece.
- `spawnAck` in 1: pulse from the piece generator.
- `spawnBlock` in 16: new piece, valid while `spawnAck` is high.
- `gameOver` out 1: sticky until reset.
- `busy` out 1: high in every state except IDLE.

## Operation
- **States:** SPAWN_WAIT, SPAWN_CHECK, IDLE, EVAL, LOCK, CLEAR_WAIT, OVER.
- **Reset values:** state = SPAWN_WAIT, `curBlock` = 0, `curX` = `SPAWN_X`, `curY` = `SPAWN_Y`, `moveSel` = 4, all pulses and `gameOver` = 0, `spawnReq` = 1, `busy` = 1. Pending flags are cleared.
- **SPAWN_WAIT:**
  - `spawnReq` = 1.
  - On `spawnAck`: `curBlock` ← `spawnBlock`, `curX`/`curY` ← `SPAWN_X`/`SPAWN_Y`, go to SPAWN_CHECK.
- **SPAWN_CHECK:**
  - `moveSel` = 4.
  - `predOK` = 1 → IDLE.
  - `predOK` = 0 → OVER.
- **Pending latches** (4 flags: L, R, ROT, DN):
  - Set by their pulse in any state except LOCK, CLEAR_WAIT, SPAWN_*, OVER; pulses arriving in those states are dropped.
  - `tick` and `reqDown` both set DN; if both arrive in the same cycle, only one down is performed.
  - A flag that is set again while already pending stays a single request.
- **IDLE arbitration** (fixed priority DN > ROT > L/R):
  - If L and R are both pending, both are cleared with no move, and arbitration continues with the remaining flags in the same cycle.
  - The winner's flag is cleared, `moveSel` is registered, and the state goes to EVAL.
  - No flag pending → stay in IDLE.
- **EVAL** (one cycle; the predictor is combinational on registered inputs):
  - Left, `predOK`: `curX` ← `curX` − 1.
  - Right, `predOK`: `curX` ← `curX` + 1.
  - Rotate, `predOK`: `curBlock` ← `predRotBlock`.
  - Down, `predOK` and not `predTouch`: `curY` ← `curY` + 1.
  - Down, `predTouch` or not `predOK`: go to LOCK with no commit.
  - Illegal left/right/rotate: no commit.
  - All cases except the lock case return to IDLE.
- **Width:** X/Y arithmetic is 5-bit unsigned. Wrap is never committed because legality is the predictor's responsibility; the scheduler never commits with `predOK` = 0.
- **LOCK:** `fieldWe` = 1 for exactly one cycle, all pending flags are cleared, then CLEAR_WAIT.
- **CLEAR_WAIT:** `clearReq` = 1 until `clearDone`, then SPAWN_WAIT.
- **OVER:** terminal state. Ignores all inputs; `gameOver` = 1 and `busy` = 1. Only `resetn` exits.

## Timing
- A request pulse at edge n sets its flag at edge n.
- From IDLE, the commit (or the transition to LOCK) happens at edge n+2. The minimum spacing between two accepted moves is 2 cycles.
- `moveSel`, `curX`, `curY` and `curBlock` are all registered and stable for the whole EVAL cycle.
- `fieldWe` is asserted in the cycle after the failing down EVAL. `curBlock`/`curX`/`curY` hold the locked piece while `fieldWe` is high.
- `spawnAck` and `clearDone` are sampled only in their own states; pulses arriving in other states are ignored.
- `spawnAck` in the same cycle as `resetn` deassertion is ignored.
- Reset asserted mid-EVAL or mid-LOCK returns immediately to the reset values; no partial commit and no `fieldWe` pulse.

## Structure
- Shared package `tetris_pkg` holds:
  - `FIELD_W` = 20 and `FIELD_H` = 20.
  - The `moveSel` encoding constants (`MV_LEFT`, `MV_RIGHT`, `MV_ROT`, `MV_DOWN`, `MV_CHECK`).
  - The state enum.
- One sub-module, `move_req_arbiter`: pending latches, the drop gate, L/R cancel and the priority encoder.
  - Inputs: the pulses, `accept`, `flush`.
  - Outputs: `grantValid` and `grantSel`.
- The top level holds the FSM and the piece registers.

## Test plan
- **Reset and spawn:** reset, then `spawnAck` with `spawnBlock` = 16'h0F00 and `predOK` = 1 → `curX` = 8, `curY` = 0, state IDLE and `busy` = 0 two cycles after the ack.
- **Left commit and reject:** `reqLeft` with `predOK` = 1 → `curX` 8 → 7 at n+2. A second `reqLeft` with `predOK` = 0 → `curX` stays at 7, `fieldWe` stays 0.
- **Same-cycle requests:** `reqLeft`, `reqRight` and `tick` all in one cycle → only down is evaluated (`moveSel` = 3), `curY` 0 → 1, `curX` unchanged, no further EVAL.
- **Lock sequence:** `tick` with `predTouch` = 1 → one `fieldWe` pulse; `clearReq` high until `clearDone`; then `spawnReq` = 1. A `reqRotate` issued during CLEAR_WAIT is never evaluated.
- **Game over:** spawn with `predOK` = 0 in SPAWN_CHECK → `gameOver` = 1 and stays 1 under any input; `resetn` low clears it.
- **Reset mid-operation:** `resetn` asserted in the EVAL cycle of a legal right move → `curX` = 8, no commit, state SPAWN_WAIT.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris move datapath: field size, predictor
// select encoding and the move scheduler state set.
package tetris_pkg;

  localparam int FIELD_W = 20;
  localparam int FIELD_H = 20;

  // moveSel encoding; the low two bits of the real moves double as the
  // index of the matching pending flag in the request arbiter.
  localparam logic [2:0] MV_LEFT  = 3'd0;
  localparam logic [2:0] MV_RIGHT = 3'd1;
  localparam logic [2:0] MV_ROT   = 3'd2;
  localparam logic [2:0] MV_DOWN  = 3'd3;
  localparam logic [2:0] MV_CHECK = 3'd4;

  typedef enum logic [2:0] {
    SPAWN_WAIT,
    SPAWN_CHECK,
    IDLE,
    EVAL,
    LOCK,
    CLEAR_WAIT,
    OVER
  } sched_state_e;

endpackage

// File: rtl/move_scheduler_if.sv
// Bundle between the move scheduler and its surroundings: player/gravity
// requests, the shared predictor, the field write strobe and the
// line-clear / piece-generator handshakes.
interface move_scheduler_if;

  logic        reqLeft;
  logic        reqRight;
  logic        reqRotate;
  logic        reqDown;
  logic        tick;

  logic [2:0]  moveSel;
  logic [15:0] curBlock;
  logic [4:0]  curX;
  logic [4:0]  curY;
  logic        predOK;
  logic        predTouch;
  logic [15:0] predRotBlock;

  logic        fieldWe;
  logic        clearReq;
  logic        clearDone;
  logic        spawnReq;
  logic        spawnAck;
  logic [15:0] spawnBlock;

  logic        gameOver;
  logic        busy;

  // Scheduler side.
  modport master (
    input  reqLeft, reqRight, reqRotate, reqDown, tick,
    input  predOK, predTouch, predRotBlock,
    input  clearDone, spawnAck, spawnBlock,
    output moveSel, curBlock, curX, curY,
    output fieldWe, clearReq, spawnReq, gameOver, busy
  );

  // Environment side: keyboard, gravity, predictors, field, clear, generator.
  modport slave (
    output reqLeft, reqRight, reqRotate, reqDown, tick,
    output predOK, predTouch, predRotBlock,
    output clearDone, spawnAck, spawnBlock,
    input  moveSel, curBlock, curX, curY,
    input  fieldWe, clearReq, spawnReq, gameOver, busy
  );

endinterface

// File: rtl/move_req_arbiter.sv
// Pending-request latches with a drop gate, left/right cancellation and a
// fixed-priority (down > rotate > left/right) grant for the scheduler.
module move_req_arbiter
  import tetris_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       reqLeft,
  input  logic       reqRight,
  input  logic       reqRotate,
  input  logic       reqDown,
  input  logic       tick,
  input  logic       accept,
  input  logic       flush,
  output logic       grantValid,
  output logic [2:0] grantSel
);

  // Flag order {DN, ROT, R, L} so a flag index equals its moveSel code.
  logic [3:0] pend_q;
  logic [3:0] pend_d;
  logic [3:0] live;

  // Opposing left+right cancel each other when the scheduler arbitrates;
  // the survivors are priority encoded in the same cycle.
  always_comb begin
    live = pend_q;
    if (accept && pend_q[0] && pend_q[1]) begin
      live[1:0] = 2'b00;
    end
    grantValid = |live;
    grantSel   = MV_CHECK;
    if (live[3]) begin
      grantSel = MV_DOWN;
    end else if (live[2]) begin
      grantSel = MV_ROT;
    end else if (live[0]) begin
      grantSel = MV_LEFT;
    end else if (live[1]) begin
      grantSel = MV_RIGHT;
    end
  end

  // Next flags: flush empties and drops, otherwise consume the winner and
  // merge this cycle's pulses (tick and reqDown share one flag).
  always_comb begin
    pend_d = 4'b0000;
    if (!flush) begin
      pend_d = live;
      if (accept && grantValid) begin
        pend_d[grantSel[1:0]] = 1'b0;
      end
      pend_d = pend_d | {reqDown | tick, reqRotate, reqRight, reqLeft};
    end
  end

  // Pending flag register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_q <= 4'b0000;
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// Move sequencer: arbitrates player/gravity requests onto the shared
// predictor, commits legal moves to the piece registers and walks the
// lock -> line-clear -> spawn sequence, ending in a sticky game-over.
module move_scheduler
  import tetris_pkg::*;
#(
  parameter logic [4:0] SPAWN_X = 5'd8,
  parameter logic [4:0] SPAWN_Y = 5'd0
)
(
  input logic              clk,
  input logic              resetn,
  move_scheduler_if.master bus
);

  sched_state_e state_q;
  logic [2:0]   moveSel_q;
  logic [15:0]  curBlock_q;
  logic [4:0]   curX_q;
  logic [4:0]   curY_q;
  logic         fieldWe_q;
  logic         clearReq_q;
  logic         spawnReq_q;
  logic         gameOver_q;
  logic         busy_q;
  logic         armed_q;

  logic         grantValid;
  logic [2:0]   grantSel;
  logic         accept;
  logic         flush;

  assign accept = (state_q == IDLE);
  assign flush  = !((state_q == IDLE) || (state_q == EVAL));

  move_req_arbiter u_arb (
    .clk        (clk),
    .resetn     (resetn),
    .reqLeft    (bus.reqLeft),
    .reqRight   (bus.reqRight),
    .reqRotate  (bus.reqRotate),
    .reqDown    (bus.reqDown),
    .tick       (bus.tick),
    .accept     (accept),
    .flush      (flush),
    .grantValid (grantValid),
    .grantSel   (grantSel)
  );

  // Main FSM with registered outputs; armed_q blanks a spawnAck that lands
  // on the first edge after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= SPAWN_WAIT;
      moveSel_q  <= MV_CHECK;
      curBlock_q <= 16'h0000;
      curX_q     <= SPAWN_X;
      curY_q     <= SPAWN_Y;
      fieldWe_q  <= 1'b0;
      clearReq_q <= 1'b0;
      spawnReq_q <= 1'b1;
      gameOver_q <= 1'b0;
      busy_q     <= 1'b1;
      armed_q    <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      case (state_q)
        SPAWN_WAIT: begin
          if (bus.spawnAck && armed_q) begin
            curBlock_q <= bus.spawnBlock;
            curX_q     <= SPAWN_X;
            curY_q     <= SPAWN_Y;
            moveSel_q  <= MV_CHECK;
            spawnReq_q <= 1'b0;
            state_q    <= SPAWN_CHECK;
          end
        end
        SPAWN_CHECK: begin
          if (bus.predOK) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gameOver_q <= 1'b1;
            state_q    <= OVER;
          end
        end
        IDLE: begin
          if (grantValid) begin
            moveSel_q <= grantSel;
            busy_q    <= 1'b1;
            state_q   <= EVAL;
          end
        end
        EVAL: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
          case (moveSel_q)
            MV_LEFT:  if (bus.predOK) curX_q <= curX_q - 5'd1;
            MV_RIGHT: if (bus.predOK) curX_q <= curX_q + 5'd1;
            MV_ROT:   if (bus.predOK) curBlock_q <= bus.predRotBlock;
            MV_DOWN: begin
              if (bus.predOK && !bus.predTouch) begin
                curY_q <= curY_q + 5'd1;
              end else begin
                busy_q    <= 1'b1;
                fieldWe_q <= 1'b1;
                state_q   <= LOCK;
              end
            end
            default: ;
          endcase
        end
        LOCK: begin
          fieldWe_q  <= 1'b0;
          clearReq_q <= 1'b1;
          state_q    <= CLEAR_WAIT;
        end
        CLEAR_WAIT: begin
          if (bus.clearDone) begin
            clearReq_q <= 1'b0;
            spawnReq_q <= 1'b1;
            state_q    <= SPAWN_WAIT;
          end
        end
        OVER: begin
          gameOver_q <= 1'b1;
          busy_q     <= 1'b1;
        end
        default: begin
          state_q <= SPAWN_WAIT;
        end
      endcase
    end
  end

  assign bus.moveSel  = moveSel_q;
  assign bus.curBlock = curBlock_q;
  assign bus.curX     = curX_q;
  assign bus.curY     = curY_q;
  assign bus.fieldWe  = fieldWe_q;
  assign bus.clearReq = clearReq_q;
  assign bus.spawnReq = spawnReq_q;
  assign bus.gameOver = gameOver_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Bench for move_scheduler: directed walk through spawn, moves, lock,
// game-over and mid-move reset, then randomized traffic, all compared each
// cycle against a behavioural game model.
module tb_move_scheduler;

  logic clk = 1'b0;
  logic resetn;

  // 10 ns system clock.
  always #5 clk = ~clk;

  move_scheduler_if bus();

  move_scheduler #(.SPAWN_X(5'd8), .SPAWN_Y(5'd0)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  localparam int P_SPAWN = 0;
  localparam int P_CHECK = 1;
  localparam int P_IDLE  = 2;
  localparam int P_EVAL  = 3;
  localparam int P_LOCK  = 4;
  localparam int P_CLEAR = 5;
  localparam int P_OVER  = 6;

  int         phase;
  bit [3:0]   pend;
  bit [2:0]   mSel;
  bit [15:0]  mBlock;
  bit [4:0]   mX;
  bit [4:0]   mY;
  bit         armed;

  int vectors     = 0;
  int miscompares = 0;
  int overCycles  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    phase  = P_SPAWN;
    pend   = 4'b0000;
    mSel   = 3'd4;
    mBlock = 16'h0000;
    mX     = 5'd8;
    mY     = 5'd0;
    armed  = 1'b0;
  endtask

  // One clock of the game rules, using the inputs sampled at this edge.
  task automatic modelStep();
    int nxt;
    bit [3:0] p;
    if (!resetn) begin
      modelReset();
      return;
    end
    nxt = phase;
    p   = pend;
    case (phase)
      P_SPAWN: if (bus.spawnAck && armed) begin
        mBlock = bus.spawnBlock; mX = 5'd8; mY = 5'd0; mSel = 3'd4; nxt = P_CHECK;
      end
      P_CHECK: nxt = bus.predOK ? P_IDLE : P_OVER;
      P_IDLE: begin
        if (p[0] && p[1]) p[1:0] = 2'b00;
        if (p[3])      begin p[3] = 1'b0; mSel = 3'd3; nxt = P_EVAL; end
        else if (p[2]) begin p[2] = 1'b0; mSel = 3'd2; nxt = P_EVAL; end
        else if (p[0]) begin p[0] = 1'b0; mSel = 3'd0; nxt = P_EVAL; end
        else if (p[1]) begin p[1] = 1'b0; mSel = 3'd1; nxt = P_EVAL; end
      end
      P_EVAL: begin
        nxt = P_IDLE;
        if (mSel == 3'd0 && bus.predOK) mX = mX - 5'd1;
        if (mSel == 3'd1 && bus.predOK) mX = mX + 5'd1;
        if (mSel == 3'd2 && bus.predOK) mBlock = bus.predRotBlock;
        if (mSel == 3'd3) begin
          if (bus.predOK && !bus.predTouch) mY = mY + 5'd1;
          else nxt = P_LOCK;
        end
      end
      P_LOCK:  nxt = P_CLEAR;
      P_CLEAR: if (bus.clearDone) nxt = P_SPAWN;
      default: ;
    endcase
    if (phase == P_IDLE || phase == P_EVAL)
      p = p | {bus.reqDown | bus.tick, bus.reqRotate, bus.reqRight, bus.reqLeft};
    else
      p = 4'b0000;
    pend  = p;
    phase = nxt;
    armed = 1'b1;
  endtask

  task automatic compareAll();
    checkOutput("moveSel",  bus.moveSel,  mSel);
    checkOutput("curBlock", bus.curBlock, mBlock);
    checkOutput("curX",     bus.curX,     mX);
    checkOutput("curY",     bus.curY,     mY);
    checkOutput("fieldWe",  bus.fieldWe,  phase == P_LOCK);
    checkOutput("clearReq", bus.clearReq, phase == P_CLEAR);
    checkOutput("spawnReq", bus.spawnReq, phase == P_SPAWN);
    checkOutput("gameOver", bus.gameOver, phase == P_OVER);
    checkOutput("busy",     bus.busy,     phase != P_IDLE);
  endtask

  // Advance one clock: DUT and model see the same inputs at the edge,
  // outputs are compared on the falling edge, then pulses are withdrawn.
  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll();
    bus.reqLeft   = 1'b0;
    bus.reqRight  = 1'b0;
    bus.reqRotate = 1'b0;
    bus.reqDown   = 1'b0;
    bus.tick      = 1'b0;
    bus.spawnAck  = 1'b0;
    bus.clearDone = 1'b0;
  endtask

  task automatic doReset();
    resetn = 1'b0;
    modelReset();
    applyStimulus();
    resetn = 1'b1;
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus();
  endtask

  initial begin
    resetn           = 1'b0;
    bus.reqLeft      = 1'b0;
    bus.reqRight     = 1'b0;
    bus.reqRotate    = 1'b0;
    bus.reqDown      = 1'b0;
    bus.tick         = 1'b0;
    bus.predOK       = 1'b1;
    bus.predTouch    = 1'b0;
    bus.predRotBlock = 16'h0000;
    bus.clearDone    = 1'b0;
    bus.spawnAck     = 1'b0;
    bus.spawnBlock   = 16'h0000;
    modelReset();
    @(negedge clk);

    // Reset values, ack on the release edge ignored, then a clean spawn.
    doReset();
    checkOutput("rstCurX", bus.curX, 8);
    checkOutput("rstSel", bus.moveSel, 4);
    checkOutput("rstSpawnReq", bus.spawnReq, 1);
    bus.spawnAck = 1'b1; bus.spawnBlock = 16'h0F00;
    applyStimulus();
    checkOutput("ackIgnored", bus.spawnReq, 1);
    bus.spawnAck = 1'b1;
    runCycles(2);
    checkOutput("spawnIdle", bus.busy, 0);
    checkOutput("spawnBlock", bus.curBlock, 16'h0F00);

    // Legal left, then rejected left.
    bus.reqLeft = 1'b1;
    runCycles(3);
    checkOutput("leftOk", bus.curX, 7);
    bus.reqLeft = 1'b1; bus.predOK = 1'b0;
    runCycles(3);
    checkOutput("leftRej", bus.curX, 7);
    checkOutput("leftRejWe", bus.fieldWe, 0);
    bus.predOK = 1'b1;

    // Left + right + tick together: only the down is evaluated.
    bus.reqLeft = 1'b1; bus.reqRight = 1'b1; bus.tick = 1'b1;
    runCycles(2);
    checkOutput("sameSel", bus.moveSel, 3);
    applyStimulus();
    checkOutput("sameY", bus.curY, 1);
    checkOutput("sameX", bus.curX, 7);
    applyStimulus();
    checkOutput("sameNoEval", bus.busy, 0);

    // Lock sequence with a rotate dropped during LOCK and CLEAR_WAIT.
    bus.tick = 1'b1; bus.predTouch = 1'b1;
    runCycles(3);
    checkOutput("lockWe", bus.fieldWe, 1);
    checkOutput("lockY", bus.curY, 1);
    bus.predTouch = 1'b0; bus.reqRotate = 1'b1;
    applyStimulus();
    checkOutput("lockWeOnce", bus.fieldWe, 0);
    checkOutput("clearReq", bus.clearReq, 1);
    bus.reqRotate = 1'b1;
    runCycles(2);
    bus.clearDone = 1'b1;
    applyStimulus();
    checkOutput("respawnReq", bus.spawnReq, 1);
    bus.spawnAck = 1'b1; bus.spawnBlock = 16'h4E00;
    runCycles(4);
    checkOutput("rotDropped", bus.moveSel, 4);

    // Reset during the EVAL cycle of a legal right move.
    bus.reqRight = 1'b1;
    runCycles(2);
    checkOutput("rightEval", bus.moveSel, 1);
    doReset();
    checkOutput("midRstX", bus.curX, 8);
    checkOutput("midRstWe", bus.fieldWe, 0);
    checkOutput("midRstSpawn", bus.spawnReq, 1);

    // Spawn check fails: sticky game over until reset.
    bus.spawnAck = 1'b1;
    applyStimulus();
    bus.spawnAck = 1'b1; bus.predOK = 1'b0;
    runCycles(2);
    checkOutput("overSet", bus.gameOver, 1);
    for (int k = 0; k < 8; k++) begin
      bus.tick = 1'b1; bus.reqLeft = 1'(k); bus.spawnAck = 1'b1; bus.predOK = 1'(k);
      applyStimulus();
    end
    checkOutput("overSticky", bus.gameOver, 1);
    doReset();
    checkOutput("overCleared", bus.gameOver, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0 || overCycles > 12) begin
        doReset();
        overCycles = 0;
      end
      bus.reqLeft      = ($urandom_range(0, 4) == 0);
      bus.reqRight     = ($urandom_range(0, 4) == 0);
      bus.reqRotate    = ($urandom_range(0, 4) == 0);
      bus.reqDown      = ($urandom_range(0, 5) == 0);
      bus.tick         = ($urandom_range(0, 5) == 0);
      bus.predOK       = ($urandom_range(0, 7) != 0);
      bus.predTouch    = ($urandom_range(0, 5) == 0);
      bus.predRotBlock = 16'($urandom);
      bus.spawnAck     = ($urandom_range(0, 2) == 0);
      bus.spawnBlock   = 16'($urandom);
      bus.clearDone    = ($urandom_range(0, 2) == 0);
      applyStimulus();
      if (phase == P_OVER) overCycles++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
